// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with a valid/ready handshake, a one-entry skid
// buffer, a synchronous flush, and a saturating back-pressure counter.
module id_ex_stage_reg #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned INSTR_WIDTH = 15,
  parameter int unsigned WB_WIDTH    = 2,
  parameter int unsigned MEM_WIDTH   = 3,
  parameter int unsigned EX_WIDTH    = 4,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                   clock,
  input  logic                   startin,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INSTR_WIDTH-1:0] instruction_input,
  input  logic [DATA_WIDTH-1:0]  pc_plus_4_input,
  input  logic [DATA_WIDTH-1:0]  sign_extend_in,
  input  logic [DATA_WIDTH-1:0]  read_data_1_input,
  input  logic [DATA_WIDTH-1:0]  read_data_2_input,
  input  logic [WB_WIDTH-1:0]    WB_input,
  input  logic [MEM_WIDTH-1:0]   MEM_input,
  input  logic [EX_WIDTH-1:0]    EX_input,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_WIDTH-1:0] instruction_output,
  output logic [DATA_WIDTH-1:0]  pc_plus_4_output,
  output logic [DATA_WIDTH-1:0]  sign_extend_out,
  output logic [DATA_WIDTH-1:0]  read_data_1_output,
  output logic [DATA_WIDTH-1:0]  read_data_2_output,
  output logic [WB_WIDTH-1:0]    WB_output,
  output logic [MEM_WIDTH-1:0]   MEM_output,
  output logic [EX_WIDTH-1:0]    EX_output,
  output logic [CNT_WIDTH-1:0]   stall_count
);

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [DATA_WIDTH-1:0]  pc_plus_4;
    logic [DATA_WIDTH-1:0]  imm;
    logic [DATA_WIDTH-1:0]  rd1;
    logic [DATA_WIDTH-1:0]  rd2;
    logic [WB_WIDTH-1:0]    wb;
    logic [MEM_WIDTH-1:0]   mem;
    logic [EX_WIDTH-1:0]    ex;
  } bundle_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  bundle_t                in_b;
  bundle_t                main_q, main_d;
  bundle_t                skid_q, skid_d;
  logic                   main_valid_q, main_valid_d;
  logic                   skid_valid_q, skid_valid_d;
  logic                   in_ready_q, in_ready_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   accept;

  // Pack the incoming ID fields into one bundle.
  always_comb begin
    in_b.instr     = instruction_input;
    in_b.pc_plus_4 = pc_plus_4_input;
    in_b.imm       = sign_extend_in;
    in_b.rd1       = read_data_1_input;
    in_b.rd2       = read_data_2_input;
    in_b.wb        = WB_input;
    in_b.mem       = MEM_input;
    in_b.ex        = EX_input;
  end

  // Next-state: main/skid movement, flush squash, stall counting.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    cnt_d        = cnt_q;
    accept       = in_valid & in_ready_q;

    if (flush) begin
      // Squash both entries; control groups forced to a bubble.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      main_d.wb    = '0;
      main_d.mem   = '0;
      main_d.ex    = '0;
    end else begin
      if (!main_valid_q || out_ready) begin
        if (skid_valid_q) begin
          // Older bundle in skid goes first to keep FIFO order.
          main_d       = skid_q;
          main_valid_d = 1'b1;
          skid_valid_d = accept;
          if (accept) begin
            skid_d = in_b;
          end
        end else if (accept) begin
          main_d       = in_b;
          main_valid_d = 1'b1;
        end else begin
          // Nothing to load: emit a bubble, data fields keep their values.
          main_valid_d = 1'b0;
          main_d.wb    = '0;
          main_d.mem   = '0;
          main_d.ex    = '0;
        end
      end else if (accept) begin
        skid_d       = in_b;
        skid_valid_d = 1'b1;
      end

      if (main_valid_q && !out_ready && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end

    in_ready_d = ~skid_valid_d;
  end

  // State registers; reset clears everything and holds in_ready low.
  always_ff @(posedge clock or negedge startin) begin
    if (!startin) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
      cnt_q        <= '0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      cnt_q        <= cnt_d;
    end
  end

  assign in_ready           = in_ready_q;
  assign out_valid          = main_valid_q;
  assign instruction_output = main_q.instr;
  assign pc_plus_4_output   = main_q.pc_plus_4;
  assign sign_extend_out    = main_q.imm;
  assign read_data_1_output = main_q.rd1;
  assign read_data_2_output = main_q.rd2;
  assign WB_output          = main_q.wb;
  assign MEM_output         = main_q.mem;
  assign EX_output          = main_q.ex;
  assign stall_count        = cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboard bench for id_ex_stage_reg (instantiated with a 4-bit stall counter).
module tb_id_ex_stage_reg;

  localparam int unsigned DW  = 32;
  localparam int unsigned IW  = 15;
  localparam int unsigned WW  = 2;
  localparam int unsigned MW  = 3;
  localparam int unsigned EW  = 4;
  localparam int unsigned CW  = 4;

  typedef struct packed {
    logic [IW-1:0] instr;
    logic [DW-1:0] pc;
    logic [DW-1:0] imm;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic [WW-1:0] wb;
    logic [MW-1:0] mem;
    logic [EW-1:0] ex;
  } bundle_t;

  logic          clock;
  logic          startin;
  logic          in_valid;
  logic          in_ready;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] stall_count;
  bundle_t       in_b;
  bundle_t       out_b;

  int vectors     = 0;
  int miscompares = 0;
  bundle_t q[$];

  id_ex_stage_reg #(
    .DATA_WIDTH(DW), .INSTR_WIDTH(IW), .WB_WIDTH(WW),
    .MEM_WIDTH(MW), .EX_WIDTH(EW), .CNT_WIDTH(CW)
  ) dut (
    .clock              (clock),
    .startin            (startin),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .instruction_input  (in_b.instr),
    .pc_plus_4_input    (in_b.pc),
    .sign_extend_in     (in_b.imm),
    .read_data_1_input  (in_b.rd1),
    .read_data_2_input  (in_b.rd2),
    .WB_input           (in_b.wb),
    .MEM_input          (in_b.mem),
    .EX_input           (in_b.ex),
    .flush              (flush),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .instruction_output (out_b.instr),
    .pc_plus_4_output   (out_b.pc),
    .sign_extend_out    (out_b.imm),
    .read_data_1_output (out_b.rd1),
    .read_data_2_output (out_b.rd2),
    .WB_output          (out_b.wb),
    .MEM_output         (out_b.mem),
    .EX_output          (out_b.ex),
    .stall_count        (stall_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic bundle_t mk(input logic [IW-1:0] instr, input logic [DW-1:0] rd1);
    bundle_t b;
    b.instr = instr;
    b.pc    = {17'h0, instr} + 32'h4;
    b.imm   = ~rd1;
    b.rd1   = rd1;
    b.rd2   = rd1 ^ 32'h5A5A_5A5A;
    b.wb    = instr[1:0];
    b.mem   = instr[4:2];
    b.ex    = instr[8:5] | 4'h1;
    return b;
  endfunction

  // One clock: scoreboard push/pop on the pre-edge handshake, then advance to the next negedge.
  task automatic step();
    bundle_t exp;
    if (startin) begin
      if (flush) begin
        q.delete();
      end else begin
        if (out_valid && out_ready) begin
          vectors++;
          if (q.size() == 0) begin
            miscompares++;
            $display("FAIL sb_unexpected got=%h exp=<none>", out_b);
          end else begin
            exp = q.pop_front();
            if (out_b !== exp) begin
              miscompares++;
              $display("FAIL sb_data got=%h exp=%h", out_b, exp);
            end
          end
        end
        if (!out_valid) begin
          vectors++;
          if ({out_b.wb, out_b.mem, out_b.ex} !== '0) begin
            miscompares++;
            $display("FAIL bubble_ctrl got=%h exp=0", {out_b.wb, out_b.mem, out_b.ex});
          end
        end
        if (in_valid && in_ready) q.push_back(in_b);
      end
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    startin   = 1'b0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    in_b      = '0;
    #1;
    vectors++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || stall_count !== '0 || out_b !== '0) begin
      miscompares++;
      $display("FAIL reset_state got=%b%b%h/%h exp=000/0", in_ready, out_valid, stall_count, out_b);
    end
    @(negedge clock);
    @(negedge clock);
    startin = 1'b1;
    step();
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_after_release got=%b exp=1", in_ready);
    end
  endtask

  task automatic test_single_pass();
    bundle_t b;
    b = '{instr: 15'h1A3F, pc: 32'h0000_0004, imm: 32'h0000_0008, rd1: 32'h1234_5678,
          rd2: 32'h8765_4321, wb: 2'b10, mem: 3'b101, ex: 4'b1100};
    in_b = b; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_b !== b) begin
      miscompares++;
      $display("FAIL single_pass got=%b/%h exp=1/%h", out_valid, out_b, b);
    end
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_b = mk(15'h2B4C, 32'h9ABC_DEF0); in_valid = 1'b1;
    step();
    in_b = mk(15'h3C5D, 32'h1111_1111);
    step();
    in_valid = 1'b0;
    vectors++;
    if (out_b.instr !== 15'h2B4C || in_ready !== 1'b0 || stall_count !== 4'd1) begin
      miscompares++;
      $display("FAIL bp_hold got=%h/%b/%0d exp=2b4c/0/1", out_b.instr, in_ready, stall_count);
    end
    step();
    vectors++;
    if (out_b.instr !== 15'h2B4C || stall_count !== 4'd2) begin
      miscompares++;
      $display("FAIL bp_count got=%h/%0d exp=2b4c/2", out_b.instr, stall_count);
    end
    out_ready = 1'b1;
    step();
    vectors++;
    if (out_valid !== 1'b1 || out_b.instr !== 15'h3C5D || in_ready !== 1'b1 || stall_count !== 4'd2) begin
      miscompares++;
      $display("FAIL bp_drain got=%b/%h/%b/%0d exp=1/3c5d/1/2", out_valid, out_b.instr, in_ready, stall_count);
    end
    step();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_b = mk(15'h0C01, 32'hC0C0_0001); in_valid = 1'b1;
    step();
    in_b = mk(15'h0D02, 32'hD0D0_0002);
    step();
    in_b = mk(15'h0E03, 32'hE0E0_0003);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || {out_b.wb, out_b.mem, out_b.ex} !== '0 || in_ready !== 1'b1 || stall_count !== 4'd3) begin
      miscompares++;
      $display("FAIL flush_state got=%b/%h/%b/%0d exp=0/0/1/3", out_valid,
               {out_b.wb, out_b.mem, out_b.ex}, in_ready, stall_count);
    end
    out_ready = 1'b1;
    step();
    step();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_no_ghost got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_b = mk(15'h0F04, 32'hF0F0_0004); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    vectors++;
    if (out_valid !== 1'b1 || stall_count !== 4'd5) begin
      miscompares++;
      $display("FAIL pre_reset got=%b/%0d exp=1/5", out_valid, stall_count);
    end
    #2 startin = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_b !== '0 || stall_count !== '0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset got=%b/%h/%0d/%b exp=0/0/0/0", out_valid, out_b, stall_count, in_ready);
    end
    q.delete();
    @(negedge clock);
    startin = 1'b1;
    step();
  endtask

  task automatic test_saturation();
    int exp_cnt;
    out_ready = 1'b0;
    in_b = mk(15'h1105, 32'h1100_0005); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      exp_cnt = (k > 15) ? 15 : k;
      vectors++;
      if (stall_count !== CW'(exp_cnt) || out_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL saturate_%0d got=%0d/%b exp=%0d/1", k, stall_count, out_valid, exp_cnt);
      end
    end
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_streaming();
    bundle_t sent[8];
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sent[i] = mk(IW'(15'h2000 + i * 15'h111), 32'hA000_0000 + 32'(i * 32'h0101_0101));
      in_b = sent[i]; in_valid = 1'b1;
      vectors++;
      if (in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL stream_ready_%0d got=%b exp=1", i, in_ready);
      end
      step();
      vectors++;
      if (out_valid !== 1'b1 || out_b !== sent[i]) begin
        miscompares++;
        $display("FAIL stream_out_%0d got=%b/%h exp=1/%h", i, out_valid, out_b, sent[i]);
      end
    end
    in_valid = 1'b0;
    step();
    vectors++;
    if (out_valid !== 1'b0 || q.size() != 0 || stall_count !== 4'd15) begin
      miscompares++;
      $display("FAIL stream_end got=%b/%0d/%0d exp=0/0/15", out_valid, q.size(), stall_count);
    end
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_saturation();
    test_streaming();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- Parametrised successor to the fixed-width ID/EX pipeline register.
- Carries the decoded-instruction bundle from ID to EX:
  - fields: instruction, pc+4, sign-extended immediate, two register read values, WB/MEM/EX control groups.
- Adds a valid/ready handshake with a one-entry skid buffer, a synchronous flush that inserts bubbles, and a saturating stall-cycle counter for performance monitoring.
- Sits between the decode stage and the ALU/forwarding logic.

Parameters:
- DATA_WIDTH, 32, width of pc_plus_4, sign_extend, read_data_1, read_data_2
- INSTR_WIDTH, 15, width of the forwarded instruction field
- WB_WIDTH, 2, width of the WB control group
- MEM_WIDTH, 3, width of the MEM control group
- EX_WIDTH, 4, width of the EX control group
- CNT_WIDTH, 16, width of stall_count

Ports:
- clock  in  1  rising-edge clock
- startin  in  1  asynchronous active-low reset
- in_valid  in  1  ID bundle valid
- in_ready  out  1  stage can accept a bundle this cycle
- instruction_input  in  INSTR_WIDTH  instruction field
- pc_plus_4_input  in  DATA_WIDTH  PC+4
- sign_extend_in  in  DATA_WIDTH  sign-extended immediate
- read_data_1_input  in  DATA_WIDTH  register read 1
- read_data_2_input  in  DATA_WIDTH  register read 2
- WB_input  in  WB_WIDTH  WB control
- MEM_input  in  MEM_WIDTH  MEM control
- EX_input  in  EX_WIDTH  EX control
- flush  in  1  synchronous flush (branch/exception squash)
- out_valid  out  1  EX bundle valid
- out_ready  in  1  EX consumes bundle this cycle
- instruction_output  out  INSTR_WIDTH  registered field
- pc_plus_4_output  out  DATA_WIDTH  registered field
- sign_extend_out  out  DATA_WIDTH  registered field
- read_data_1_output  out  DATA_WIDTH  registered field
- read_data_2_output  out  DATA_WIDTH  registered field
- WB_output  out  WB_WIDTH  registered field
- MEM_output  out  MEM_WIDTH  registered field
- EX_output  out  EX_WIDTH  registered field
- stall_count  out  CNT_WIDTH  saturating count of back-pressure cycles

Behaviour:
- Reset (startin=0, asynchronous, dominates all other inputs):
  - main and skid entries invalid, all data/control registers 0.
  - out_valid=0, stall_count=0.
  - in_ready=0 while startin=0; in_ready=1 from the first cycle after release.
- Storage: main entry (drives outputs) and skid entry. in_ready = !skid_valid; it is a registered value.
- Accept: in_valid & in_ready at a rising edge.
- Main-entry load, evaluated each edge when the main entry is empty or out_ready=1:
  - load skid if skid valid, else load the accepted input;
  - if neither is available, the main entry goes invalid.
- Skid load: if main is valid, out_ready=0 and an input is accepted, the input goes to skid. Next cycle in_ready=0.
- Latency: an input accepted at edge N with an empty/draining pipe is on the outputs with out_valid=1 after edge N (1 cycle).
- Ordering is strictly FIFO. A bundle is never duplicated or dropped except by flush.
- Simultaneous accept + out_ready with skid valid: skid→main, input→skid. Skid stays valid, no loss.
- Bubble rule: WB_output, MEM_output and EX_output read 0 whenever out_valid=0. Data fields hold their last values.
- Flush at an edge:
  - main and skid become invalid;
  - any same-cycle input is discarded (flush beats accept);
  - in_ready=1 next cycle;
  - stall_count unchanged.
- stall_count:
  - +1 on each edge where out_valid=1 & out_ready=0 & flush=0;
  - saturates at 2^CNT_WIDTH−1, no wrap;
  - cleared only by reset.
- Widths are fixed by the parameters. No arithmetic on data fields.

Test Plan:
- Reset then single pass:
  - Release startin. Present in_valid=1 with instr=0x1A3F, pc=0x00000004, imm=0x00000008, rd1=0x12345678, rd2=0x87654321, WB=2'b10, MEM=3'b101, EX=4'b1100, out_ready=1.
  - Required: after the next edge, out_valid=1 and every output equals its input.
- Back-pressure/skid:
  - Hold out_ready=0, send 0x2B4C/0x9ABCDEF0 then 0x3C5D/0x11111111.
  - Required: the first bundle stays on the outputs, in_ready=0 after the second accept, stall_count increments each cycle.
  - Raise out_ready: outputs show 0x2B4C then 0x3C5D on consecutive cycles.
- Flush with skid full and in_valid=1:
  - Required: next cycle out_valid=0, WB/MEM/EX outputs=0, in_ready=1; the flushed input never appears.
- Mid-operation reset:
  - Drop startin while out_valid=1 and stall_count=5.
  - Required: out_valid=0, all outputs 0 and stall_count=0 immediately, without waiting for a clock edge.
- Saturation with CNT_WIDTH=4:
  - Hold out_valid=1, out_ready=0 for 20 cycles.
  - Required: stall_count=15 and stays at 15.
- Streaming with out_ready=1 and in_valid=1 every cycle for 8 bundles:
  - Required: outputs match inputs delayed by one cycle, in_ready stays 1 throughout.
